// File: rtl/mdr_mem_ctrl_if.sv
// RAM-side bus of the MDR memory controller: registered address, write data and strobes out,
// read data back from the RAM.
interface mdr_mem_ctrl_if;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_re;
    logic        mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mdr_mem_ctrl.sv
// MDR and single-word RAM access sequencer (IDLE -> ACCESS -> DONE).
// Define MEM_RANGE_CHK_EN to fault requests whose address is at or beyond MEM_DEPTH.
module mdr_mem_ctrl #(
    parameter int          WAIT_STATES = 1,
    parameter int          MEM_DEPTH   = 512,
    parameter logic [31:0] MDR_INIT    = 32'h0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [8:0]            mar_addr,
    input  logic [31:0]           bus_in,
    input  logic                  mdr_in,
    input  logic                  read,
    input  logic                  write,
    mdr_mem_ctrl_if.master        mem,
    output logic [31:0]           mdr_out,
    output logic                  busy,
    output logic                  done,
    output logic                  fault
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic [31:0] mdr_q, mdr_next;
    logic [8:0]  addr_q, addr_next;
    logic [31:0] wdata_q, wdata_next;
    logic        re_q, re_next;
    logic        we_q, we_next;
    logic        fault_q, fault_next;
    logic        out_of_range;

`ifdef MEM_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    // Widened compare so a depth of 512 never truncates to zero.
    assign out_of_range = RANGE_CHK && ({1'b0, mar_addr} >= 10'(MEM_DEPTH));

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            mdr_q   <= MDR_INIT;
            addr_q  <= 9'd0;
            wdata_q <= 32'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            mdr_q   <= mdr_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            re_q    <= re_next;
            we_q    <= we_next;
            fault_q <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mdr_next   = mdr_q;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        re_next    = re_q;
        we_next    = 1'b0;
        fault_next = 1'b0;

        case (state)
            IDLE: begin
                if (read || write) begin
                    if (out_of_range) begin
                        state_next = DONE;
                        fault_next = 1'b1;
                    end else begin
                        state_next = ACCESS;
                        addr_next  = mar_addr;
                        cnt_next   = 3'(WAIT_STATES);
                        if (read) begin
                            re_next = 1'b1;
                        end else begin
                            we_next    = 1'b1;
                            wdata_next = mdr_q;
                        end
                    end
                end else if (mdr_in) begin
                    mdr_next = bus_in;
                end
            end
            ACCESS: begin
                // re_q stays high for the whole access only when the access is a read.
                if (cnt == 3'd0) begin
                    state_next = DONE;
                    re_next    = 1'b0;
                    if (re_q) begin
                        mdr_next = mem.mem_rdata;
                    end
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_re    = re_q;
    assign mem.mem_we    = we_q;
    assign mdr_out       = mdr_q;
    assign busy          = (state == ACCESS);
    assign done          = (state == DONE);
    assign fault         = fault_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Bench for mdr_mem_ctrl: two instances (WAIT_STATES 1 and 2) share the CPU-side stimulus,
// each with its own synchronous RAM and a transaction-timing model of expected outputs.
module tb_mdr_mem_ctrl;

    localparam logic [31:0] MDR_INIT = 32'h1234_5678;
    localparam int          DEPTH    = 256;

`ifdef MEM_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic        read;
    logic        write;
    logic        mdr_in;
    logic [8:0]  mar_addr;
    logic [31:0] bus_in;

    logic [1:0][31:0] mdr_out_w;
    logic [1:0][31:0] wdata_w;
    logic [1:0][8:0]  addr_w;
    logic [1:0]       busy_w;
    logic [1:0]       done_w;
    logic [1:0]       fault_w;
    logic [1:0]       re_w;
    logic [1:0]       we_w;

    int total;
    int bad;

    function automatic logic [31:0] init_word(int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    function automatic bit addr_bad(logic [8:0] a);
        return CHK && ({1'b0, a} >= 10'(DEPTH));
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        mdr_mem_ctrl_if mif ();
        logic [31:0] ram [512];

        mdr_mem_ctrl #(
            .WAIT_STATES(g + 1),
            .MEM_DEPTH  (DEPTH),
            .MDR_INIT   (MDR_INIT)
        ) dut (
            .clk     (clk),
            .clr     (clr),
            .mar_addr(mar_addr),
            .bus_in  (bus_in),
            .mdr_in  (mdr_in),
            .read    (read),
            .write   (write),
            .mem     (mif.master),
            .mdr_out (mdr_out_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g]),
            .fault   (fault_w[g])
        );

        assign addr_w[g]  = mif.mem_addr;
        assign wdata_w[g] = mif.mem_wdata;
        assign re_w[g]    = mif.mem_re;
        assign we_w[g]    = mif.mem_we;

        initial begin
            for (int k = 0; k < 512; k++) ram[k] = init_word(k);
        end

        // Synchronous RAM: one cycle of read latency.
        always @(posedge clk) begin
            if (mif.mem_re) mif.mem_rdata <= ram[mif.mem_addr];
            if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
        end
    end

    // Transaction model: m_age counts edges since a request was accepted; index i has WAIT_STATES=i+1.
    bit          m_active [2];
    int          m_age    [2];
    bit          m_rd     [2];
    bit          m_wr     [2];
    bit          m_oor    [2];
    logic [8:0]  m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_mdr    [2];
    logic [31:0] m_ram    [2][512];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 512; k++) m_ram[i][k] = init_word(k);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_active[i] <= 1'b0;
                m_age[i]    <= 0;
                m_rd[i]     <= 1'b0;
                m_wr[i]     <= 1'b0;
                m_oor[i]    <= 1'b0;
                m_addr[i]   <= 9'd0;
                m_wdata[i]  <= 32'd0;
                m_mdr[i]    <= MDR_INIT;
            end else if (!m_active[i]) begin
                if (read || write) begin
                    m_active[i] <= 1'b1;
                    m_age[i]    <= 0;
                    m_oor[i]    <= addr_bad(mar_addr);
                    m_rd[i]     <= read && !addr_bad(mar_addr);
                    m_wr[i]     <= !read && write && !addr_bad(mar_addr);
                    if (!addr_bad(mar_addr)) begin
                        m_addr[i] <= mar_addr;
                        if (!read) m_wdata[i] <= m_mdr[i];
                    end
                end else if (mdr_in) begin
                    m_mdr[i] <= bus_in;
                end
            end else begin
                m_age[i] <= m_age[i] + 1;
                if (m_oor[i]) begin
                    m_active[i] <= 1'b0;
                end else begin
                    if (m_wr[i] && m_age[i] == 0) m_ram[i][m_addr[i]] <= m_wdata[i];
                    if (m_rd[i] && m_age[i] == i + 1) m_mdr[i] <= m_ram[i][m_addr[i]];
                    if (m_age[i] == i + 2) m_active[i] <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s inst=%0d got=%h exp=%h", name, inst, got, exp);
        end
    endtask

    task automatic checkModel();
        for (int i = 0; i < 2; i++) begin
            bit e_busy;
            bit e_done;
            e_busy = m_active[i] && !m_oor[i] && (m_age[i] <= i + 1);
            e_done = m_active[i] && (m_oor[i] ? (m_age[i] == 0) : (m_age[i] == i + 2));
            checkOutput("model_mdr",   i, mdr_out_w[i], m_mdr[i]);
            checkOutput("model_addr",  i, 32'(addr_w[i]), 32'(m_addr[i]));
            checkOutput("model_wdata", i, wdata_w[i], m_wdata[i]);
            checkOutput("model_busy",  i, 32'(busy_w[i]), 32'(e_busy));
            checkOutput("model_re",    i, 32'(re_w[i]), 32'(e_busy && m_rd[i]));
            checkOutput("model_we",    i, 32'(we_w[i]),
                        32'(m_active[i] && m_wr[i] && m_age[i] == 0));
            checkOutput("model_done",  i, 32'(done_w[i]), 32'(e_done));
            checkOutput("model_fault", i, 32'(fault_w[i]),
                        32'(m_active[i] && m_oor[i] && m_age[i] == 0));
        end
    endtask

    // Inputs change just after a negedge; the next posedge samples them; outputs checked at the negedge after.
    task automatic applyStimulus(input logic c, input logic rd, input logic wr, input logic mi,
                                 input logic [8:0] a, input logic [31:0] b);
        clr      = c;
        read     = rd;
        write    = wr;
        mdr_in   = mi;
        mar_addr = a;
        bus_in   = b;
        @(negedge clk);
        checkModel();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_mdr",  i, mdr_out_w[i], 32'h1234_5678);
            checkOutput("rst_busy", i, 32'(busy_w[i]), 32'd0);
            checkOutput("rst_done", i, 32'(done_w[i]), 32'd0);
            checkOutput("rst_addr", i, 32'(addr_w[i]), 32'd0);
        end

        // MDR load then write to address 5.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 32'hDEAD_BEEF);
        checkOutput("load_mdr", 0, mdr_out_w[0], 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 9'h005, 32'd0);
        checkOutput("wr_we",    0, 32'(we_w[0]), 32'd1);
        checkOutput("wr_addr",  0, 32'(addr_w[0]), 32'h5);
        checkOutput("wr_wdata", 0, wdata_w[0], 32'hDEAD_BEEF);
        checkOutput("wr_busy",  0, 32'(busy_w[0]), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("wr_we_drop", 0, 32'(we_w[0]), 32'd0);
        checkOutput("wr_busy2",   0, 32'(busy_w[0]), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("wr_done", 0, 32'(done_w[0]), 32'd1);
        idle(4);
        checkOutput("wr_ram0", 0, g_inst[0].ram[5], 32'hDEAD_BEEF);
        checkOutput("wr_ram1", 1, g_inst[1].ram[5], 32'hDEAD_BEEF);

        // Read address 5 back into a cleared MDR.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 32'd0);
        checkOutput("clr_mdr", 0, mdr_out_w[0], 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h005, 32'd0);
        checkOutput("rd_re", 0, 32'(re_w[0]), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("rd_early_done", 0, 32'(done_w[0]), 32'd0);
        checkOutput("rd_early_mdr",  0, mdr_out_w[0], 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("rd_done", 0, 32'(done_w[0]), 32'd1);
        checkOutput("rd_mdr",  0, mdr_out_w[0], 32'hDEAD_BEEF);
        idle(4);

        // Read and write together: read wins.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 9'h007, 32'd0);
        checkOutput("rw_re", 0, 32'(re_w[0]), 32'd1);
        checkOutput("rw_we", 0, 32'(we_w[0]), 32'd0);
        idle(2);
        checkOutput("rw_done", 0, 32'(done_w[0]), 32'd1);
        checkOutput("rw_mdr",  0, mdr_out_w[0], 32'hA5A5_0007);
        idle(4);
        checkOutput("rw_ram0", 0, g_inst[0].ram[7], 32'hA5A5_0007);
        checkOutput("rw_ram1", 1, g_inst[1].ram[7], 32'hA5A5_0007);

        // Requests and MDR loads while busy are ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h003, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 9'h009, 32'h1111_1111);
        checkOutput("busy_mdr",  0, mdr_out_w[0], 32'hA5A5_0007);
        checkOutput("busy_addr", 0, 32'(addr_w[0]), 32'h3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 9'h00A, 32'h2222_2222);
        checkOutput("busy_done", 0, 32'(done_w[0]), 32'd1);
        checkOutput("busy_rd",   0, mdr_out_w[0], 32'hA5A5_0003);
        idle(4);

        // Reset in the middle of a read on the two-wait-state instance.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h004, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("abort_busy_pre", 1, 32'(busy_w[1]), 32'd1);
        checkOutput("abort_re_pre",   1, 32'(re_w[1]), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("abort_mdr",  1, mdr_out_w[1], 32'h1234_5678);
        checkOutput("abort_busy", 1, 32'(busy_w[1]), 32'd0);
        checkOutput("abort_re",   1, 32'(re_w[1]), 32'd0);
        checkOutput("abort_mdr0", 0, mdr_out_w[0], 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            checkOutput("abort_no_done", 1, 32'(done_w[1]), 32'd0);
        end

        // Read beyond MEM_DEPTH.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF, 32'd0);
`ifdef MEM_RANGE_CHK_EN
        checkOutput("oor_fault", 0, 32'(fault_w[0]), 32'd1);
        checkOutput("oor_done",  0, 32'(done_w[0]), 32'd1);
        checkOutput("oor_re",    0, 32'(re_w[0]), 32'd0);
        checkOutput("oor_mdr",   0, mdr_out_w[0], 32'h1234_5678);
        checkOutput("oor_fault1", 1, 32'(fault_w[1]), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        checkOutput("oor_fault_drop", 0, 32'(fault_w[0]), 32'd0);
        checkOutput("oor_done_drop",  0, 32'(done_w[0]), 32'd0);
`else
        checkOutput("hi_fault", 0, 32'(fault_w[0]), 32'd0);
        checkOutput("hi_re",    0, 32'(re_w[0]), 32'd1);
        checkOutput("hi_addr",  0, 32'(addr_w[0]), 32'h1FF);
        idle(2);
        checkOutput("hi_done", 0, 32'(done_w[0]), 32'd1);
        checkOutput("hi_mdr",  0, mdr_out_w[0], 32'hA5A5_01FF);
`endif
        idle(5);

        // Write just past the range limit, then back-to-back reads.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 9'h100, 32'd0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h0FF, 32'd0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9'h001, 32'd0);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
